median_filter_3x3: RTL

//  3x3 median filter on an 8-bit grey pixel stream in the cam_pclk domain.

---
 rtl/median_filter_3x3_if.sv | 27 ++
 rtl/median_filter_3x3.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/median_filter_3x3_if.sv
// Pixel stream bundle for the 3x3 median filter.
// Master drives the pre_* stream and mode; slave returns the post_* stream.
interface median_filter_3x3_if;
   logic       median_en;
   logic       pre_frame_vsync;
   logic       pre_frame_hsync;
   logic       pre_frame_valid;
   logic [7:0] pre_frame_data;
   logic       post_frame_vsync;
   logic       post_frame_hsync;
   logic       post_frame_valid;
   logic [7:0] post_frame_data;

   modport master (
      output median_en, pre_frame_vsync, pre_frame_hsync,
      output pre_frame_valid, pre_frame_data,
      input  post_frame_vsync, post_frame_hsync,
      input  post_frame_valid, post_frame_data
   );

   modport slave (
      input  median_en, pre_frame_vsync, pre_frame_hsync,
      input  pre_frame_valid, pre_frame_data,
      output post_frame_vsync, post_frame_hsync,
      output post_frame_valid, post_frame_data
   );
endinterface

// File: rtl/median_filter_3x3.sv
// 3x3 median filter on an 8-bit grey stream, fixed 4-cycle latency.
// Two line buffers feed a shifting window, then a 3-stage sort network.
module median_filter_3x3 #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int LAT   = 4
) (
   input logic                clk,
   input logic                rst_n,
   median_filter_3x3_if.slave bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef logic [7:0] pix_t;
   typedef struct packed {
      logic vld;
      logic brd;
      logic md;
   } tag_t;

   function automatic pix_t max2(pix_t a, pix_t b);
      return (a > b) ? a : b;
   endfunction

   function automatic pix_t min2(pix_t a, pix_t b);
      return (a < b) ? a : b;
   endfunction

   function automatic pix_t max3(pix_t a, pix_t b, pix_t c);
      return max2(max2(a, b), c);
   endfunction

   function automatic pix_t min3(pix_t a, pix_t b, pix_t c);
      return min2(min2(a, b), c);
   endfunction

   function automatic pix_t med3(pix_t a, pix_t b, pix_t c);
      return max2(min2(a, b), min2(max2(a, b), c));
   endfunction

   logic [CW-1:0] col_q, col_d, col_cur;
   logic [RW-1:0] row_q, row_d, row_cur;
   logic          vs_prev_q, hs_prev_q;
   logic          en_q, en_d;
   logic          vs_rise, hs_fall;

   pix_t lb1_mem [IMG_W];
   pix_t lb2_mem [IMG_W];
   pix_t lb1_rd, lb2_rd;

   logic [2:0][2:0][7:0] win_q, win_d;
   logic [2:0][2:0][7:0] s1_q, s1_d;
   logic [2:0][7:0]      s2_q, s2_d;
   pix_t                 c1_q, c1_d, c2_q, c2_d;
   pix_t                 med;
   tag_t                 t0_q, t0_d, t1_q, t1_d, t2_q, t2_d;
   pix_t                 data_q, data_d;
   logic                 vld_q, vld_d;
   logic [LAT-1:0]       vs_sr_q, vs_sr_d, hs_sr_q, hs_sr_d;

   // Pixel coordinates for this cycle (edge clears first), next counters
   always_comb begin
      vs_rise = bus.pre_frame_vsync & ~vs_prev_q;
      hs_fall = ~bus.pre_frame_hsync & hs_prev_q;
      en_d    = vs_rise ? bus.median_en : en_q;
      col_cur = (vs_rise | hs_fall) ? '0 : col_q;
      row_cur = vs_rise ? '0 : row_q;
      col_d   = col_cur;
      row_d   = row_cur;
      if (bus.pre_frame_valid) begin
         if (col_cur == COL_LAST) begin
            col_d = '0;
            if (row_cur != ROW_LAST) row_d = row_cur + RW'(1);
         end else begin
            col_d = col_cur + CW'(1);
         end
      end
   end

   // Window shift, sort network and output select
   always_comb begin
      lb1_rd = lb1_mem[col_cur];
      lb2_rd = lb2_mem[col_cur];
      win_d  = win_q;
      t0_d   = '0;
      if (bus.pre_frame_valid) begin
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = lb2_rd;
         win_d[1][2] = lb1_rd;
         win_d[2][2] = bus.pre_frame_data;
         t0_d.vld    = 1'b1;
         t0_d.brd    = (row_cur < RW'(2)) | (col_cur < CW'(2));
         t0_d.md     = en_d;
      end
      for (int r = 0; r < 3; r++) begin
         s1_d[r][2] = max3(win_q[r][0], win_q[r][1], win_q[r][2]);
         s1_d[r][1] = med3(win_q[r][0], win_q[r][1], win_q[r][2]);
         s1_d[r][0] = min3(win_q[r][0], win_q[r][1], win_q[r][2]);
      end
      s2_d[2] = min3(s1_q[0][2], s1_q[1][2], s1_q[2][2]);
      s2_d[1] = med3(s1_q[0][1], s1_q[1][1], s1_q[2][1]);
      s2_d[0] = max3(s1_q[0][0], s1_q[1][0], s1_q[2][0]);
      med     = med3(s2_q[2], s2_q[1], s2_q[0]);
      c1_d    = win_q[1][1];
      c2_d    = c1_q;
      t1_d    = t0_q;
      t2_d    = t1_q;
      vld_d   = t2_q.vld;
      data_d  = '0;
      if (t2_q.vld && !t2_q.brd) data_d = t2_q.md ? med : c2_q;
      vs_sr_d = {vs_sr_q[LAT-2:0], bus.pre_frame_vsync};
      hs_sr_d = {hs_sr_q[LAT-2:0], bus.pre_frame_hsync};
   end

   // Line buffers: read-before-write, never reset (border masks stale data)
   always_ff @(posedge clk) begin
      if (bus.pre_frame_valid) begin
         lb2_mem[col_cur] <= lb1_rd;
         lb1_mem[col_cur] <= bus.pre_frame_data;
      end
   end

   // Counters, window, pipeline and sync delay registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q     <= '0;
         row_q     <= '0;
         vs_prev_q <= 1'b0;
         hs_prev_q <= 1'b0;
         en_q      <= 1'b1;
         win_q     <= '0;
         s1_q      <= '0;
         s2_q      <= '0;
         c1_q      <= '0;
         c2_q      <= '0;
         t0_q      <= '0;
         t1_q      <= '0;
         t2_q      <= '0;
         data_q    <= '0;
         vld_q     <= 1'b0;
         vs_sr_q   <= '0;
         hs_sr_q   <= '0;
      end else begin
         col_q     <= col_d;
         row_q     <= row_d;
         vs_prev_q <= bus.pre_frame_vsync;
         hs_prev_q <= bus.pre_frame_hsync;
         en_q      <= en_d;
         win_q     <= win_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         c1_q      <= c1_d;
         c2_q      <= c2_d;
         t0_q      <= t0_d;
         t1_q      <= t1_d;
         t2_q      <= t2_d;
         data_q    <= data_d;
         vld_q     <= vld_d;
         vs_sr_q   <= vs_sr_d;
         hs_sr_q   <= hs_sr_d;
      end
   end

   assign bus.post_frame_vsync = vs_sr_q[LAT-1];
   assign bus.post_frame_hsync = hs_sr_q[LAT-1];
   assign bus.post_frame_valid = vld_q;
   assign bus.post_frame_data  = data_q;
endmodule
